// File: rtl/slot_pkg.sv
// Shared types and default configuration for the slot reel animation path.
//
// Contents:
//   NUM_SYMBOLS, SYM_W       - symbols per reel strip and index width
//   SPRITE_H, OFF_W          - symbol height in pixels and scroll offset width
//   SPEED                    - pixels scrolled per frame while spinning
//   MIN_SPIN_FRAMES,
//   STAGGER_FRAMES           - stop scheduling defaults
//   spin_state_t             - sequencer FSM states
//   reel_pos_t               - one reel position {sym, offset} at the default sizes
//   commit_frame()           - frame number from which reel k may stop
package slot_pkg;

  localparam int NUM_SYMBOLS     = 8;
  localparam int SYM_W           = 3;
  localparam int SPRITE_H        = 64;
  localparam int OFF_W           = 6;
  localparam int SPEED           = 8;
  localparam int MIN_SPIN_FRAMES = 60;
  localparam int STAGGER_FRAMES  = 30;
  localparam int NUM_REELS       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    DONE = 2'd2
  } spin_state_t;

  // Position of one reel as seen by the sprite memory controller.
  typedef struct packed {
    logic [SYM_W-1:0] sym;
    logic [OFF_W-1:0] offset;
  } reel_pos_t;

  // Reels stop in stagger order: reel k is not allowed to stop before this frame.
  function automatic int commit_frame(input int min_frames, input int stagger, input int k);
    return min_frames + k * stagger;
  endfunction

endpackage

// File: rtl/reel_spin_sequencer_if.sv
// Bundle between the command side / sprite side and the reel spin sequencer.
//
// Signals:
//   vsync        - VGA vertical sync, active low (master -> sequencer)
//   start_spin   - spin request (master -> sequencer)
//   reel_target  - final symbols {reel2, reel1, reel0} (master -> sequencer)
//   reel_sym     - current top symbol per reel (sequencer -> master)
//   reel_offset  - current scroll offset per reel (sequencer -> master)
//   reel_stopped - per-reel stopped flags (sequencer -> master)
//   busy         - spin in progress (sequencer -> master)
//   done         - one-cycle pulse when the last reel stops (sequencer -> master)
//
// master: the environment driving requests; slave: the sequencer itself.
interface reel_spin_sequencer_if
  import slot_pkg::*;
#(
  parameter int SYM_W = slot_pkg::SYM_W,
  parameter int OFF_W = slot_pkg::OFF_W
) ();

  logic                 vsync;
  logic                 start_spin;
  logic [3*SYM_W-1:0]   reel_target;
  logic [3*SYM_W-1:0]   reel_sym;
  logic [3*OFF_W-1:0]   reel_offset;
  logic [2:0]           reel_stopped;
  logic                 busy;
  logic                 done;

  modport master (
    output vsync, start_spin, reel_target,
    input  reel_sym, reel_offset, reel_stopped, busy, done
  );

  modport slave (
    input  vsync, start_spin, reel_target,
    output reel_sym, reel_offset, reel_stopped, busy, done
  );

endinterface

// File: rtl/reel_scroller.sv
// One reel: scrolls by STEP pixels per tick, advancing the top symbol each
// time the offset wraps past a full sprite, and freezes once it lands on its
// target after being allowed to stop.
//
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   clear      - start of a new spin: release the reel (position is kept)
//   tick       - one frame step while spinning
//   commit     - frame count has reached this reel's commit frame
//   target     - symbol this reel must land on
//   sym        - current top symbol
//   offset     - current scroll offset within the sprite
//   stopped    - reel has landed and is frozen
module reel_scroller
  import slot_pkg::*;
#(
  parameter int NUM_SYM   = slot_pkg::NUM_SYMBOLS,
  parameter int SYM_BITS  = slot_pkg::SYM_W,
  parameter int SPRITE_PX = slot_pkg::SPRITE_H,
  parameter int OFF_BITS  = slot_pkg::OFF_W,
  parameter int STEP      = slot_pkg::SPEED
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                tick,
  input  logic                commit,
  input  logic [SYM_BITS-1:0] target,
  output logic [SYM_BITS-1:0] sym,
  output logic [OFF_BITS-1:0] offset,
  output logic                stopped
);

  typedef struct packed {
    logic [SYM_BITS-1:0] sym;
    logic [OFF_BITS-1:0] offset;
  } pos_t;

  pos_t pos_reg, pos_next;
  logic stopped_reg, stopped_next;

  // One extra bit so offset + STEP never overflows before the wrap compare.
  logic [OFF_BITS:0] off_sum;

  always_comb begin
    pos_next     = pos_reg;
    stopped_next = stopped_reg;
    off_sum      = {1'b0, pos_reg.offset} + (OFF_BITS + 1)'(STEP);

    if (clear) begin
      stopped_next = 1'b0;
    end else if (tick && !stopped_reg) begin
      if (off_sum >= (OFF_BITS + 1)'(SPRITE_PX)) begin
        pos_next.offset = OFF_BITS'(off_sum - (OFF_BITS + 1)'(SPRITE_PX));
        pos_next.sym    = (pos_reg.sym == SYM_BITS'(NUM_SYM - 1)) ? '0
                                                                  : pos_reg.sym + SYM_BITS'(1);
      end else begin
        pos_next.offset = off_sum[OFF_BITS-1:0];
      end
      // The stop decision looks at the position after this tick's scroll, so
      // the frozen image is exactly the target symbol with zero offset.
      if (commit && (pos_next.sym == target) && (pos_next.offset == '0)) begin
        stopped_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_reg     <= '0;
      stopped_reg <= 1'b1;
    end else begin
      pos_reg     <= pos_next;
      stopped_reg <= stopped_next;
    end
  end

  assign sym     = pos_reg.sym;
  assign offset  = pos_reg.offset;
  assign stopped = stopped_reg;

endmodule

// File: rtl/reel_spin_sequencer.sv
// Frame-synchronous spin controller for the three slot reels.
// Latches the final symbols on an accepted start, scrolls every moving reel
// once per frame, lets reel k stop from its staggered commit frame onward and
// pulses done once the last reel has landed.
//
// Ports:
//   clk   - pixel/system clock
//   reset - synchronous active-high reset (aborts a spin without a done pulse)
//   bus   - slave side of reel_spin_sequencer_if (vsync, start_spin,
//           reel_target in; reel_sym, reel_offset, reel_stopped, busy, done out)
module reel_spin_sequencer
  import slot_pkg::*;
#(
  parameter int NUM_SYMBOLS     = slot_pkg::NUM_SYMBOLS,
  parameter int SYM_W           = slot_pkg::SYM_W,
  parameter int SPRITE_H        = slot_pkg::SPRITE_H,
  parameter int OFF_W           = slot_pkg::OFF_W,
  parameter int SPEED           = slot_pkg::SPEED,
  parameter int MIN_SPIN_FRAMES = slot_pkg::MIN_SPIN_FRAMES,
  parameter int STAGGER_FRAMES  = slot_pkg::STAGGER_FRAMES
) (
  input logic                  clk,
  input logic                  reset,
  reel_spin_sequencer_if.slave bus
);

  // Wide enough to hold the last reel's commit frame; saturates above that.
  localparam int FC_W = $clog2(MIN_SPIN_FRAMES + 2 * STAGGER_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_MAX = '1;

  spin_state_t              state_reg;
  logic [FC_W-1:0]          frame_cnt_reg;
  logic [FC_W-1:0]          frame_inc;
  logic [3*SYM_W-1:0]       target_reg;
  logic                     busy_reg;
  logic                     done_reg;
  logic                     vsync_d_reg;
  logic                     frame_tick_reg;

  logic                     clear;
  logic                     spin_tick;
  logic [2:0]               commit;
  logic [2:0]               stopped_vec;
  logic [SYM_W-1:0]         sym_arr    [3];
  logic [OFF_W-1:0]         offset_arr [3];

  // A start is only accepted from IDLE; a tick in that same cycle is dropped
  // because spin_tick is gated by the SPIN state.
  assign clear     = (state_reg == IDLE) && bus.start_spin;
  assign spin_tick = frame_tick_reg && (state_reg == SPIN);
  assign frame_inc = (frame_cnt_reg == FC_MAX) ? frame_cnt_reg : frame_cnt_reg + FC_W'(1);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_reel
      // Compared against the incremented count: the commit applies to the
      // frame being processed by this tick.
      assign commit[gi] = frame_inc >= FC_W'(commit_frame(MIN_SPIN_FRAMES, STAGGER_FRAMES, gi));

      reel_scroller #(
        .NUM_SYM   (NUM_SYMBOLS),
        .SYM_BITS  (SYM_W),
        .SPRITE_PX (SPRITE_H),
        .OFF_BITS  (OFF_W),
        .STEP      (SPEED)
      ) u_reel (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .tick    (spin_tick),
        .commit  (commit[gi]),
        .target  (target_reg[gi*SYM_W +: SYM_W]),
        .sym     (sym_arr[gi]),
        .offset  (offset_arr[gi]),
        .stopped (stopped_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      frame_cnt_reg  <= '0;
      target_reg     <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      vsync_d_reg    <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      // Registered falling-edge detect: tick lands one clk after vsync falls.
      vsync_d_reg    <= bus.vsync;
      frame_tick_reg <= vsync_d_reg & ~bus.vsync;
      done_reg       <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (bus.start_spin) begin
            target_reg    <= bus.reel_target;
            frame_cnt_reg <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= SPIN;
          end
        end
        SPIN: begin
          if (frame_tick_reg) begin
            frame_cnt_reg <= frame_inc;
          end
          // Stopped flags were cleared on entry, so this cannot fire early.
          if (&stopped_vec) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.reel_sym    = '0;
    bus.reel_offset = '0;
    for (int i = 0; i < 3; i++) begin
      bus.reel_sym[i*SYM_W +: SYM_W]    = sym_arr[i];
      bus.reel_offset[i*OFF_W +: OFF_W] = offset_arr[i];
    end
  end

  assign bus.reel_stopped = stopped_vec;
  assign bus.busy         = busy_reg;
  assign bus.done         = done_reg;

endmodule
